// File: rtl/picosoc_bus_arb_pkg.sv
// Shared types and constants for the PicoRV32 two-master bus arbiter.
package picosoc_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'h0000_0000;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/picosoc_bus_arb_if.sv
// Bundle of both upstream masters, the downstream SoC bus and arbiter status.
// slave: the arbiter's view.  master: the view of the requesters and SoC bus around it.
interface picosoc_bus_arb_if;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;
    logic        timeout_pulse;

    modport slave (
        input  m0_valid, m0_instr, m0_addr, m0_wdata, m0_wstrb,
        input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
        input  s_ready, s_rdata,
        output m0_ready, m0_rdata, m1_ready, m1_rdata,
        output s_valid, s_instr, s_addr, s_wdata, s_wstrb,
        output grant, timeout_pulse
    );

    modport master (
        output m0_valid, m0_instr, m0_addr, m0_wdata, m0_wstrb,
        output m1_valid, m1_addr, m1_wdata, m1_wstrb,
        output s_ready, s_rdata,
        input  m0_ready, m0_rdata, m1_ready, m1_rdata,
        input  s_valid, s_instr, s_addr, s_wdata, s_wstrb,
        input  grant, timeout_pulse
    );
endinterface

// File: rtl/picosoc_bus_arb_timeout.sv
// Stall watchdog: counts granted cycles without s_ready; expired marks the
// TIMEOUT_CYCLES-th stalled cycle of a grant.
module picosoc_bus_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)    cnt_d = '0;
        else if (run) cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expired = run && (cnt_q == LAST);
endmodule

// File: rtl/picosoc_bus_arb.sv
// Two-master round-robin arbiter for the PicoRV32 native bus with grant lock.
// Define PICOSOC_BUS_TIMEOUT_EN to add the stalled-transaction watchdog.
module picosoc_bus_arb
    import picosoc_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input logic              clk,
    input logic              reset,
    picosoc_bus_arb_if.slave bus
);
    arb_state_e state_q, state_d;
    logic       last_q, last_d;   // 1: m1 was the most recent grantee
    logic       expired;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("picosoc_bus_arb: TIMEOUT_CYCLES out of range 1..65535");
    end

`ifdef PICOSOC_BUS_TIMEOUT_EN
    logic to_run, to_clear;
    assign to_run   = ((state_q == ST_GNT0 && bus.m0_valid) ||
                       (state_q == ST_GNT1 && bus.m1_valid)) && !bus.s_ready;
    assign to_clear = (state_q == ST_IDLE) || (state_d != state_q);

    picosoc_bus_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (to_clear),
        .run     (to_run),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        bus.s_valid = 1'b0;
        bus.s_instr = 1'b0;
        bus.s_addr  = '0;
        bus.s_wdata = '0;
        bus.s_wstrb = '0;
        bus.m0_ready = 1'b0;
        bus.m1_ready = 1'b0;
        bus.grant    = GRANT_NONE;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.m0_valid && (!bus.m1_valid || last_q)) state_d = ST_GNT0;
                else if (bus.m1_valid)                         state_d = ST_GNT1;
            end
            ST_GNT0: begin
                bus.grant   = GRANT_M0;
                bus.s_instr = bus.m0_instr;
                bus.s_addr  = bus.m0_addr;
                bus.s_wdata = bus.m0_wdata;
                bus.s_wstrb = bus.m0_wstrb;
                bus.s_valid = bus.m0_valid && !reset && !expired;
                // Dropping valid without ready abandons the grant silently.
                if (!bus.m0_valid) begin
                    state_d = ST_IDLE;
                end else if (bus.s_ready || expired) begin
                    bus.m0_ready = !reset;
                    last_d       = 1'b0;
                    state_d      = bus.m1_valid ? ST_GNT1 : ST_IDLE;
                end
            end
            ST_GNT1: begin
                bus.grant   = GRANT_M1;
                bus.s_addr  = bus.m1_addr;
                bus.s_wdata = bus.m1_wdata;
                bus.s_wstrb = bus.m1_wstrb;
                bus.s_valid = bus.m1_valid && !reset && !expired;
                if (!bus.m1_valid) begin
                    state_d = ST_IDLE;
                end else if (bus.s_ready || expired) begin
                    bus.m1_ready = !reset;
                    last_d       = 1'b1;
                    state_d      = bus.m0_valid ? ST_GNT0 : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.m0_rdata      = expired ? ERR_RDATA : bus.s_rdata;
    assign bus.m1_rdata      = expired ? ERR_RDATA : bus.s_rdata;
    assign bus.timeout_pulse = expired && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_picosoc_bus_arb.sv
// Directed bench for picosoc_bus_arb; watchdog cases run when
// PICOSOC_BUS_TIMEOUT_EN is defined (TIMEOUT_CYCLES fixed at 8 here).
module tb_picosoc_bus_arb;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    picosoc_bus_arb_if bus ();

    picosoc_bus_arb #(.TIMEOUT_CYCLES(8), .ERR_RDATA(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the edge; outputs are checked 2 ns after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.m0_valid = 0; bus.m0_instr = 0; bus.m0_addr = 0; bus.m0_wdata = 0; bus.m0_wstrb = 0;
        bus.m1_valid = 0; bus.m1_addr = 0; bus.m1_wdata = 0; bus.m1_wstrb = 0;
        bus.s_ready = 0; bus.s_rdata = 32'hDEAD_BEEF;
        cyc(); cyc(); #1;
        check("rst_grant",   32'(bus.grant), 32'h0);
        check("rst_svalid",  32'(bus.s_valid), 32'h0);
        check("rst_m0ready", 32'(bus.m0_ready), 32'h0);
        check("rst_m1ready", 32'(bus.m1_ready), 32'h0);
        check("rst_pulse",   32'(bus.timeout_pulse), 32'h0);

        // m0 read, slave readies on the third granted cycle
        reset = 0; bus.m0_valid = 1; bus.m0_addr = 32'h0010_0000; #1;
        check("t1_idle_svalid", 32'(bus.s_valid), 32'h0);
        check("t1_idle_grant",  32'(bus.grant), 32'h0);
        cyc(); #1;
        check("t1_c1_svalid", 32'(bus.s_valid), 32'h1);
        check("t1_c1_grant",  32'(bus.grant), 32'h1);
        check("t1_c1_saddr",  bus.s_addr, 32'h0010_0000);
        check("t1_c1_ready",  32'(bus.m0_ready), 32'h0);
        cyc(); #1;
        check("t1_c2_ready",  32'(bus.m0_ready), 32'h0);
        cyc(); bus.s_ready = 1; bus.s_rdata = 32'h1234_5678; #1;
        check("t1_c3_ready",  32'(bus.m0_ready), 32'h1);
        check("t1_c3_rdata",  bus.m0_rdata, 32'h1234_5678);
        check("t1_c3_m1rd",   bus.m1_rdata, 32'h1234_5678);
        check("t1_c3_m1rdy",  32'(bus.m1_ready), 32'h0);
        cyc(); bus.m0_valid = 0; bus.s_ready = 0; #1;
        check("t1_end_grant", 32'(bus.grant), 32'h0);
        check("t1_end_ready", 32'(bus.m0_ready), 32'h0);
        check("t1_end_saddr", bus.s_addr, 32'h0);

        // Both masters valid out of reset, slave always ready
        cyc(); reset = 1; bus.m0_valid = 1; bus.m1_valid = 1;
        bus.m0_addr = 32'h0000_0100; bus.m1_addr = 32'h0000_0200; bus.s_ready = 1; #1;
        check("t2_rst_svalid", 32'(bus.s_valid), 32'h0);
        cyc(); reset = 0; #1;
        check("t2_idle_grant", 32'(bus.grant), 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            check("t2_grant",  32'(bus.grant), (i % 2 == 0) ? 32'h1 : 32'h2);
            check("t2_svalid", 32'(bus.s_valid), 32'h1);
            check("t2_m0rdy",  32'(bus.m0_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
            check("t2_m1rdy",  32'(bus.m1_ready), (i % 2 == 0) ? 32'h0 : 32'h1);
            check("t2_saddr",  bus.s_addr, (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
        end
        // Owner m0 drops valid without ready: no ready, back to idle
        cyc(); bus.m0_valid = 0; bus.m1_valid = 0; bus.s_ready = 0; #1;
        check("t2_drop_grant",  32'(bus.grant), 32'h1);
        check("t2_drop_svalid", 32'(bus.s_valid), 32'h0);
        check("t2_drop_ready",  32'(bus.m0_ready), 32'h0);
        cyc(); #1;
        check("t2_drop_idle",   32'(bus.grant), 32'h0);

        // m1 partial write; m0_instr high must not leak to s_instr
        cyc(); bus.m1_valid = 1; bus.m1_addr = 32'h0200_0004; bus.m1_wdata = 32'hCAFE_F00D;
        bus.m1_wstrb = 4'b0011; bus.m0_instr = 1; #1;
        check("t3_idle_grant", 32'(bus.grant), 32'h0);
        cyc(); #1;
        check("t3_grant",  32'(bus.grant), 32'h2);
        check("t3_svalid", 32'(bus.s_valid), 32'h1);
        check("t3_wstrb",  32'(bus.s_wstrb), 32'h3);
        check("t3_wdata",  bus.s_wdata, 32'hCAFE_F00D);
        check("t3_saddr",  bus.s_addr, 32'h0200_0004);
        check("t3_instr",  32'(bus.s_instr), 32'h0);
        check("t3_m0rdy0", 32'(bus.m0_ready), 32'h0);
        bus.s_ready = 1; #1;
        check("t3_m1rdy",  32'(bus.m1_ready), 32'h1);
        check("t3_m0rdy1", 32'(bus.m0_ready), 32'h0);
        cyc(); bus.m1_valid = 0; bus.s_ready = 0; bus.m0_instr = 0; bus.m1_wstrb = 0; #1;
        check("t3_end_grant", 32'(bus.grant), 32'h0);

        // Reset two cycles into a GNT0 stall
        cyc(); bus.m0_valid = 1; bus.m0_addr = 32'h0000_0040; #1;
        cyc(); #1;
        check("t4_c1_grant", 32'(bus.grant), 32'h1);
        cyc(); reset = 1; bus.s_ready = 1; #1;
        check("t4_rst_svalid", 32'(bus.s_valid), 32'h0);
        check("t4_rst_m0rdy",  32'(bus.m0_ready), 32'h0);
        check("t4_rst_m1rdy",  32'(bus.m1_ready), 32'h0);
        check("t4_rst_pulse",  32'(bus.timeout_pulse), 32'h0);
        cyc(); reset = 0; bus.m0_valid = 0; bus.s_ready = 0; #1;
        check("t4_after_grant", 32'(bus.grant), 32'h0);
        check("t4_after_m0rdy", 32'(bus.m0_ready), 32'h0);

`ifdef PICOSOC_BUS_TIMEOUT_EN
        // Slave never ready: forced completion on granted cycle 8
        cyc(); bus.m0_valid = 1; bus.s_rdata = 32'hDEAD_BEEF; #1;
        for (int k = 1; k <= 8; k++) begin
            cyc(); #1;
            check("t5_m0rdy",  32'(bus.m0_ready), (k == 8) ? 32'h1 : 32'h0);
            check("t5_pulse",  32'(bus.timeout_pulse), (k == 8) ? 32'h1 : 32'h0);
            check("t5_svalid", 32'(bus.s_valid), (k == 8) ? 32'h0 : 32'h1);
            if (k == 8) check("t5_rdata", bus.m0_rdata, 32'h0000_0000);
        end
        cyc(); bus.m0_valid = 0; #1;
        check("t5_end_pulse", 32'(bus.timeout_pulse), 32'h0);
        check("t5_end_grant", 32'(bus.grant), 32'h0);
        // s_ready arrives on cycle 8: real data wins, no pulse
        cyc(); bus.m0_valid = 1; #1;
        for (int k = 1; k <= 8; k++) begin
            cyc(); bus.s_ready = (k == 8); #1;
            check("t6_m0rdy", 32'(bus.m0_ready), (k == 8) ? 32'h1 : 32'h0);
            check("t6_pulse", 32'(bus.timeout_pulse), 32'h0);
            if (k == 8) check("t6_rdata", bus.m0_rdata, 32'hDEAD_BEEF);
        end
        cyc(); bus.m0_valid = 0; bus.s_ready = 0; #1;
        check("t6_end_grant", 32'(bus.grant), 32'h0);
`else
        // No watchdog: a stalled grant holds with no pulse
        cyc(); bus.m0_valid = 1; #1;
        for (int k = 1; k <= 20; k++) begin
            cyc(); #1;
            check("t5_hold_grant", 32'(bus.grant), 32'h1);
            check("t5_hold_m0rdy", 32'(bus.m0_ready), 32'h0);
            check("t5_hold_pulse", 32'(bus.timeout_pulse), 32'h0);
        end
        cyc(); bus.m0_valid = 0; #1;
        check("t5_end_grant", 32'(bus.grant), 32'h1);
        cyc(); #1;
        check("t5_idle_grant", 32'(bus.grant), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/picosoc_bus_arb.md
# picosoc_bus_arb

Two-master arbiter for the PicoRV32 native memory bus (valid/ready/addr/wdata/wstrb/rdata). It shares one downstream SoC bus (progmem, RAM, UART, iomem decode) between the CPU (master 0) and a second requester such as a DMA or debug loader (master 1). It locks the grant for the full duration of each transaction and arbitrates round-robin on contention. An optional watchdog terminates stalled transactions and raises a pulse suitable for the SoC `irq_stall` line.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: stalled-grant cycles before forced completion. Range 1..65535.
- `ERR_RDATA`, default 32'h0000_0000: read data returned on a timeout.

Ports:
- `clk` in 1: the single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `m0_valid`, `m0_instr`, `m0_addr[31:0]`, `m0_wdata[31:0]`, `m0_wstrb[3:0]` in: master 0 request.
- `m0_ready` out 1, `m0_rdata` out 32: master 0 response.
- `m1_valid`, `m1_addr[31:0]`, `m1_wdata[31:0]`, `m1_wstrb[3:0]` in: master 1 request. Master 1 has no instr input.
- `m1_ready` out 1, `m1_rdata` out 32: master 1 response.
- `s_valid`, `s_instr`, `s_addr[31:0]`, `s_wdata[31:0]`, `s_wstrb[3:0]` out: request to the SoC bus.
- `s_ready` in 1, `s_rdata` in 32: SoC bus response.
- `grant` out 2: one-hot owner; 2'b00 when idle.
- `timeout_pulse` out 1: one-cycle pulse on forced completion.

## Operation
- FSM states: IDLE, GNT0, GNT1. `last` register holds the most recent grantee.
- IDLE:
  - Only m0_valid → GNT0.
  - Only m1_valid → GNT1.
  - Both valid → the master not equal to `last`.
  - Neither → stay in IDLE.
- GNTx:
  - Slave request outputs are muxed combinationally from master x.
  - `s_valid = mx_valid && !reset`.
  - `s_instr = m0_instr` in GNT0; 0 in GNT1.
- Completion is the cycle where `s_ready` is high in GNTx:
  - `mx_ready = 1` in that cycle; `last <= x`.
  - Next state: GNTy if the other master y has valid high, else IDLE. The completing master is never re-granted in its completion cycle.
- Non-owner `m_ready` is always 0.
- `m0_rdata` and `m1_rdata` both equal `s_rdata`, or `ERR_RDATA` in a timeout cycle.
- If the owner drops valid without ready (protocol violation), the FSM returns to IDLE next cycle. No ready is issued.
- In IDLE, `s_valid = 0`; `s_addr`, `s_wdata` and `s_wstrb` are 0.

## Timing
- Reset values:
  - state IDLE, `last = 1` (m0 wins the first tie), timeout counter 0.
  - `grant = 0`, `s_valid = 0`, `m0_ready = m1_ready = 0`, `timeout_pulse = 0`.
- Request in IDLE → `s_valid` high on the next cycle: 1 cycle arbitration latency.
- Back-to-back handover from x to y: y's `s_valid` is high on the cycle after x's ready. There is no idle bubble.
- Ready path is combinational, `s_ready` → `mx_ready`, with zero added latency.
- Reset asserted mid-transaction:
  - `s_valid` is forced low in the same cycle.
  - The FSM is in IDLE the next cycle.
  - No ready is delivered to either master.

## Configuration
- Macro `PICOSOC_BUS_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to any GNT state and increments each GNT cycle without `s_ready`.
  - When it reaches `TIMEOUT_CYCLES`, that cycle is forced completion:
    - `mx_ready = 1` with `ERR_RDATA`.
    - `s_valid = 0`.
    - `timeout_pulse = 1`.
  - The FSM then follows the normal completion transition.
  - If `s_ready` arrives in the same cycle, the normal completion wins: real data, no pulse.
- Undefined: no counter; `timeout_pulse` tied to 0; a stalled grant holds forever.

## Structure
- Shared package `picosoc_bus_pkg`:
  - FSM state enum (IDLE/GNT0/GNT1).
  - Default `ERR_RDATA` constant.
  - `GRANT_NONE` / `GRANT_M0` / `GRANT_M1` encodings.
- Sub-module `picosoc_bus_timeout`:
  - Inputs: clk, reset, clear, run.
  - Output: expired.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
  - Instantiated only under the macro.

## Test plan
- Only m0 reads 32'h0010_0000; slave readies on the 3rd cycle with 32'h1234_5678 → `s_valid` rises 1 cycle after m0_valid; `m0_ready` pulses once with 32'h1234_5678; `grant` = 01 and then 00.
- m0 and m1 both valid from reset; slave readies immediately → grant order m0, m1, m0, m1; each handover has zero idle cycles; `m1_ready` never coincides with `m0_ready`.
- m1 writes 32'hCAFE_F00D with wstrb 4'b0011 to 32'h0200_0004 → `s_wstrb` = 0011 and `s_instr` = 0; `m0_ready` stays 0 throughout.
- Reset asserted 2 cycles into a GNT0 stall → `s_valid` low that cycle; `grant` = 00 next cycle; no ready pulses.
- With `PICOSOC_BUS_TIMEOUT_EN` and `TIMEOUT_CYCLES=8`, slave never readies → forced ready at cycle 8 of the grant with rdata 0; `timeout_pulse` high exactly 1 cycle. A second case with `s_ready` at cycle 8 delivers real data and no pulse.
